// File: rtl/hyper_pipe_credit_rx.sv
// Credit-return receiver FIFO at the far end of an unstalled, hyper-pipelined link.
// Optional same-cycle bypass of an empty FIFO: define HYPER_PIPE_CREDIT_RX_BYPASS_EN.
module hyper_pipe_credit_rx #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             credit_out,
  output logic [CNT_W-1:0] fill_level,
  output logic             ovf
);

  localparam int PTR_W = $clog2(DEPTH);

  // Handshake: the consumer side transfers a word on any cycle with out_valid & out_ready;
  // out_valid/out_data hold while out_ready is low. The link side has no ready at all.

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             credit_q, ovf_q;

  logic empty, full, pop, fifo_pop, push, drop;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

`ifdef HYPER_PIPE_CREDIT_RX_BYPASS_EN
  logic bypass_take;
  assign out_valid   = ~empty | in_valid;
  assign out_data    = empty ? in_data : mem[rd_ptr];
  assign pop         = out_valid & out_ready;
  // A word consumed straight off the link while empty never touches the FIFO.
  assign bypass_take = empty & in_valid & out_ready;
  assign push        = in_valid & (~full | pop) & ~bypass_take;
`else
  assign out_valid = ~empty;
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & (~full | pop);
`endif

  assign fifo_pop = pop & ~empty;
  assign drop     = in_valid & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count + CNT_W'(push) - CNT_W'(fifo_pop);
      credit_q <= pop;
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Storage carries no reset; contents are only observed behind out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  assign credit_out = credit_q;
  assign fill_level = count;
  assign ovf        = ovf_q;

endmodule
